spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- SPI mode-0 responder (slave), the far end of the team's SPI controller link.
- Lets the FPGA stand in for the external sensor, for loopback benches, or act as a peripheral to another board.
- Oversamples raw sclk/cs_n/mosi in the system clock domain, deserialises MOSI frames and serialises MISO frames MSB-first.
- Offers a valid/ready transmit buffer and a one-cycle receive strobe.

Parameters:
- DATA_W, 8, bits per frame (≥2).
- SYNC_STAGES, 2, flip-flop stages on each raw SPI input (≥2).
- IDLE_PATTERN, 8'hFF (DATA_W bits), word shifted out when no transmit data is buffered.

Ports:
- clk_i  in  1  system clock; must be ≥8× sclk frequency.
- reset_i  in  1  synchronous, active-high reset.
- sclk_i  in  1  raw SPI clock from controller, asynchronous.
- cs_n_i  in  1  raw chip select, active low, asynchronous.
- mosi_i  in  1  raw controller-out data.
- miso_o  out  1  responder-out data.
- miso_oe_o  out  1  MISO output enable; high only while selected.
- tx_data_i  in  DATA_W  word to send in a following frame.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  transmit buffer empty; a write is accepted when tx_valid_i & tx_ready_o.
- rx_data_o  out  DATA_W  last complete received word; held until the next completion.
- rx_valid_o  out  1  one-cycle strobe: rx_data_o updated.
- tx_underrun_o  out  1  one-cycle strobe: a frame started with the buffer empty.
- frame_abort_o  out  1  one-cycle strobe: cs_n deasserted mid-frame.
- busy_o  out  1  high while in ACTIVE.

Behaviour:
- Reset values (all synchronous on reset_i):
  - miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, frame_abort_o=0, busy_o=0.
  - Synchroniser chains preset to idle values: sclk=0, cs_n=1, mosi=0. State=IDLE, bit_cnt=0.
  - Reset mid-transfer abandons the frame with no strobes; the tx buffer is emptied.
- Input synchronisation and edge detection:
  - Each raw input passes through SYNC_STAGES flip-flops.
  - Edges are detected as synchronised value vs. a one-cycle-delayed copy: rise = s & ~p, fall = ~s & p; likewise for cs_n.
- Transmit buffer:
  - One DATA_W register plus a full flag; tx_ready_o = ~full.
  - A write sets full. Loading the buffer into the shifter clears full in the same cycle.
  - A write in the same cycle as a load is not seen by that load; it is stored for the next frame.
- State machine:
  - IDLE:
    - miso_oe_o=0.
    - On cs_n falling edge: go ACTIVE, bit_cnt=0, miso_oe_o=1.
    - If full, tx shifter <= buffer; otherwise tx shifter <= IDLE_PATTERN and pulse tx_underrun_o.
    - miso_o = shifter MSB from the next cycle.
  - ACTIVE, sclk rising edge:
    - rx shifter <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
    - When bit_cnt==DATA_W-1: rx_data_o <= completed word, rx_valid_o=1 for one cycle, bit_cnt wraps to 0.
  - ACTIVE, sclk falling edge:
    - If bit_cnt≠0: shift tx left and drive the next bit.
    - If bit_cnt==0 (frame boundary, back-to-back frames): reload from the buffer or IDLE_PATTERN, same underrun rule as above.
  - ACTIVE, cs_n rising edge:
    - Go IDLE, miso_oe_o=0.
    - If bit_cnt≠0: pulse frame_abort_o, discard the partial rx word, no rx_valid_o.
    - A tx word already loaded is consumed and lost.
    - cs rise has priority over an sclk edge detected in the same cycle.
- Latency: rx_valid_o is high in clk_i cycle SYNC_STAGES+1 after the first clk_i edge that samples sclk_i high for bit DATA_W-1 (cycle 3 at default).
- sclk edges while cs_n is high are ignored. bit_cnt and the shifters are untouched in IDLE.

Test Plan:
- Reset, then idle 20 cycles -> all outputs at reset values, tx_ready_o=1, miso_oe_o=0.
- Write 8'hA5, then a controller frame with MOSI=8'h3C (sclk = clk_i/10) -> MISO bits 1,0,1,0,0,1,0,1 sampled on rising sclk; rx_data_o=8'h3C with a single rx_valid_o pulse; tx_ready_o returns to 1 at cs fall.
- No buffered data, frame MOSI=8'h00 -> tx_underrun_o pulses once at cs fall, MISO reads 8'hFF, rx_data_o=8'h00.
- Two back-to-back frames under one cs_n low, buffer 8'h11, then 8'h22 written during frame 1 -> MISO 8'h11 then 8'h22; two rx_valid_o pulses.
- cs_n raised after 5 sclk rises of MOSI=8'hF0 -> frame_abort_o pulses once, no rx_valid_o, rx_data_o keeps its previous value, busy_o=0.
- reset_i asserted after 3 bits of a frame -> next cycle all outputs at reset values; a subsequent full frame 8'h81 is received correctly.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples raw sclk/cs_n/mosi in the clk_i domain,
// receives MOSI frames and sends MISO frames MSB-first from a one-word tx buffer.
module spi_responder #(
    parameter int                 DATA_W       = 8,
    parameter int                 SYNC_STAGES  = 2,
    parameter logic [DATA_W-1:0]  IDLE_PATTERN = {DATA_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              frame_abort_o,
    output logic              busy_o
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    // tx handshake: a word is taken on tx_valid_i & tx_ready_o; tx_ready_o is
    // high exactly while the single-entry buffer is empty.
    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift, tx_shift, tx_buf;
    logic                   tx_full;
    logic                   tx_write, load, rx_step, tx_step, abort;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign tx_ready_o = ~tx_full;
    assign tx_write   = tx_valid_i & ~tx_full;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // cs rise wins over an sclk edge seen in the same cycle.
    always_comb begin
        load    = 1'b0;
        rx_step = 1'b0;
        tx_step = 1'b0;
        abort   = 1'b0;
        case (state)
            ST_IDLE: load = cs_fall;
            ST_ACTIVE: begin
                if (cs_rise) begin
                    abort = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    rx_step = 1'b1;
                end else if (sclk_fall) begin
                    tx_step = (bit_cnt != '0);
                    load    = (bit_cnt == '0);
                end
            end
            default: ;
        endcase
        busy_o    = (state == ST_ACTIVE);
        miso_oe_o = (state == ST_ACTIVE);
        miso_o    = (state == ST_ACTIVE) & tx_shift[DATA_W-1];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync     <= '0;
            cs_sync       <= '1;
            mosi_sync     <= '0;
            sclk_prev     <= 1'b0;
            cs_prev       <= 1'b1;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            tx_buf        <= '0;
            tx_full       <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            frame_abort_o <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync       <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_prev     <= sclk_s;
            cs_prev       <= cs_s;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            frame_abort_o <= abort;

            // A write coinciding with a load lands in the buffer for the next frame.
            if (tx_write) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end

            if (load) begin
                tx_shift      <= tx_full ? tx_buf : IDLE_PATTERN;
                tx_underrun_o <= ~tx_full;
                bit_cnt       <= '0;
            end else if (tx_step) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (rx_step) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    bit_cnt    <= '0;
                    rx_data_o  <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_valid_o <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: drives a mode-0 controller at clk/10 and checks MISO,
// received words and strobes against a transaction-level model of the tx buffer.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       cs_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o;
    logic       tx_underrun_o, frame_abort_o, busy_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic [7:0] rx_data_o;

    int checks = 0;
    int errors = 0;

    // monitor totals
    int n_rx = 0, n_under = 0, n_abort = 0;
    logic [7:0] got_q[$];

    // reference model
    logic [7:0] exp_q[$];
    logic       model_full = 1'b0;
    logic [7:0] model_buf = 8'h00;
    logic [7:0] cur_miso = 8'h00;
    logic [7:0] last_rx = 8'h00;
    int         exp_under = 0;

    spi_responder dut (
        .clk_i(clk), .reset_i(reset_i), .sclk_i(sclk_i), .cs_n_i(cs_n_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .tx_underrun_o(tx_underrun_o), .frame_abort_o(frame_abort_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o === 1'b1) begin
            got_q.push_back(rx_data_o);
            n_rx++;
        end
        if (tx_underrun_o === 1'b1) n_under++;
        if (frame_abort_o === 1'b1) n_abort++;
    end

    // A frame boundary takes the buffered word if present, otherwise the idle word.
    task automatic model_load();
        if (model_full) begin
            cur_miso   = model_buf;
            model_full = 1'b0;
        end else begin
            cur_miso = 8'hFF;
            exp_under++;
        end
    endtask

    task automatic write_word(input logic [7:0] w);
        @(negedge clk);
        checks++;
        if (tx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL write_ready: tx_ready_o=%b expected 1", tx_ready_o);
        end
        tx_data_i  = w;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
        model_full = 1'b1;
        model_buf  = w;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n_i = 1'b0;
        model_load();
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs_n_i = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi_i = mo[7-i];
            repeat (4) @(negedge clk);
            sclk_i = 1'b1;
            mi[7-i] = miso_o;
            repeat (5) @(negedge clk);
            sclk_i = 1'b0;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] mo, input string tag);
        logic [7:0] mi, want_mi, got;
        int rx0;
        want_mi = cur_miso;
        rx0 = n_rx;
        exp_q.push_back(mo);
        spi_bits(mo, 8, mi);
        checks++;
        if (mi !== want_mi) begin
            errors++;
            $display("FAIL %s_miso: got %h expected %h", tag, mi, want_mi);
        end
        checks++;
        if (n_rx - rx0 != 1) begin
            errors++;
            $display("FAIL %s_rx_pulses: got %0d expected 1", tag, n_rx - rx0);
        end
        got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++;
        if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL %s_rx_data: got %h expected %h", tag, got, exp_q[0]);
        end
        last_rx = exp_q.pop_front();
        got_q.delete();
        model_load();
    endtask

    task automatic check_underruns(input string tag);
        checks++;
        if (n_under != exp_under) begin
            errors++;
            $display("FAIL %s_underruns: got %0d expected %0d", tag, n_under, exp_under);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] rx_exp);
        checks++;
        if ({miso_o, miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, frame_abort_o, busy_o}
            !== 7'b0010000) begin
            errors++;
            $display("FAIL %s_flags: miso=%b oe=%b rdy=%b rxv=%b und=%b abt=%b busy=%b expected 0,0,1,0,0,0,0",
                     tag, miso_o, miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, frame_abort_o, busy_o);
        end
        checks++;
        if (rx_data_o !== rx_exp) begin
            errors++;
            $display("FAIL %s_rx_data: got %h expected %h", tag, rx_data_o, rx_exp);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (20) @(negedge clk);
        check_idle_outputs("reset", 8'h00);
        checks++;
        if (n_rx != 0 || n_under != 0 || n_abort != 0) begin
            errors++;
            $display("FAIL reset_strobes: rx=%0d und=%0d abt=%0d expected 0", n_rx, n_under, n_abort);
        end
    endtask

    task automatic test_basic();
        write_word(8'hA5);
        checks++;
        if (tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_full: tx_ready_o=%b expected 0", tx_ready_o);
        end
        cs_low();
        checks++;
        if ({tx_ready_o, miso_oe_o, busy_o} !== 3'b111) begin
            errors++;
            $display("FAIL basic_active: rdy/oe/busy=%b expected 111", {tx_ready_o, miso_oe_o, busy_o});
        end
        check_underruns("basic_start");
        do_frame(8'h3C, "basic");
        cs_high();
        check_idle_outputs("basic_end", last_rx);
        check_underruns("basic_end");
    endtask

    task automatic test_underrun();
        int u0;
        u0 = n_under;
        cs_low();
        checks++;
        if (n_under - u0 != 1) begin
            errors++;
            $display("FAIL underrun_at_cs: got %0d pulses expected 1", n_under - u0);
        end
        do_frame(8'h00, "underrun");
        cs_high();
        check_underruns("underrun");
    endtask

    task automatic test_back_to_back();
        int rx0;
        rx0 = n_rx;
        write_word(8'h11);
        cs_low();
        write_word(8'h22);
        do_frame(8'($urandom_range(0, 255)), "b2b_f1");
        do_frame(8'($urandom_range(0, 255)), "b2b_f2");
        cs_high();
        checks++;
        if (n_rx - rx0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d expected 2", n_rx - rx0);
        end
        check_underruns("b2b");
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int a0, r0;
        a0 = n_abort;
        r0 = n_rx;
        cs_low();
        spi_bits(8'hF0, 5, mi);
        cs_high();
        checks++;
        if (n_abort - a0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d expected 1", n_abort - a0);
        end
        checks++;
        if (n_rx != r0) begin
            errors++;
            $display("FAIL abort_rx_pulses: got %0d expected 0", n_rx - r0);
        end
        check_idle_outputs("abort", last_rx);
        check_underruns("abort");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        int a0, r0;
        write_word(8'h5A);
        cs_low();
        spi_bits(8'hC3, 3, mi);
        @(negedge clk);
        reset_i = 1'b1;
        cs_n_i  = 1'b1;
        sclk_i  = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset", 8'h00);
        reset_i    = 1'b0;
        model_full = 1'b0;
        last_rx    = 8'h00;
        a0 = n_abort;
        r0 = n_rx;
        repeat (10) @(negedge clk);
        checks++;
        if (n_abort != a0 || n_rx != r0) begin
            errors++;
            $display("FAIL midreset_strobes: abt=%0d rx=%0d expected 0", n_abort - a0, n_rx - r0);
        end
        write_word(8'h7E);
        cs_low();
        do_frame(8'h81, "after_reset");
        cs_high();
        check_idle_outputs("after_reset", 8'h81);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1) write_word(8'($urandom_range(0, 255)));
            cs_low();
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                if ($urandom_range(0, 1) == 1) write_word(8'($urandom_range(0, 255)));
                do_frame(8'($urandom_range(0, 255)), "random");
            end
            cs_high();
            check_underruns("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
